// File: rtl/pulse_scan_controller.sv
// Start-strobe sequencer for an array of TDC test-pulse generators.
// Fires the masked channels in broadcast or round-robin scan order at a fixed period.
module pulse_scan_controller #(
  parameter int unsigned NUM_CH     = 24,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned STROBE_LEN = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        go,
  input  logic                                        stop,
  input  logic                                        mode,
  input  logic [NUM_CH-1:0]                           ch_mask,
  input  logic [CNT_W-1:0]                            period,
  input  logic [CNT_W-1:0]                            rounds,
  output logic [NUM_CH-1:0]                           start,
  output logic                                        busy,
  output logic                                        done,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur_ch,
  output logic [CNT_W-1:0]                            rounds_done
);

  localparam int unsigned      CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(STROBE_LEN + 2);
  localparam logic [CNT_W-1:0] STROBE_CNT = CNT_W'(STROBE_LEN);
  localparam logic [CNT_W-1:0] FIRE_LAST  = CNT_W'(STROBE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    rounds_q, rounds_d;
  logic [CNT_W-1:0]    period_eff_q, period_eff_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                stop_pend_q, stop_pend_d;
  logic [NUM_CH-1:0]   start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    rounds_done_q, rounds_done_d;

  logic [CH_W-1:0]     first_ch;
  logic [CH_W-1:0]     low_ch;
  logic [CH_W-1:0]     last_ch;
  logic [CH_W-1:0]     above_ch;
  logic                has_above;
  logic [CH_W-1:0]     next_ch;
  logic [CNT_W-1:0]    wait_last;
  logic                round_cmp;
  logic                stop_eff;

  // Lowest set bit of the incoming mask selects the first scan channel.
  always_comb begin
    first_ch = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = CH_W'(i);
    end
  end

  // Latched-mask scan: lowest, highest, and next-higher set bit after ch_q.
  always_comb begin
    low_ch    = '0;
    last_ch   = '0;
    above_ch  = '0;
    has_above = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_ch = CH_W'(i);
        if (CH_W'(i) > ch_q) begin
          above_ch  = CH_W'(i);
          has_above = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (mask_q[i]) last_ch = CH_W'(i);
    end
    next_ch = has_above ? above_ch : low_ch;
  end

  assign wait_last = period_eff_q - STROBE_CNT - CNT_W'(1);
  assign round_cmp = !mode_q || (ch_q == last_ch);
  // A stop seen together with the accepting go is held until the first FIRE cycle.
  assign stop_eff  = stop || stop_pend_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    mask_d        = mask_q;
    rounds_d      = rounds_q;
    period_eff_d  = period_eff_q;
    ch_d          = ch_q;
    stop_pend_d   = stop_pend_q;
    start_d       = start_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rounds_done_d = rounds_done_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          rounds_done_d = '0;
          if (|ch_mask) begin
            mode_d       = mode;
            mask_d       = ch_mask;
            rounds_d     = rounds;
            period_eff_d = (period < MIN_PERIOD) ? MIN_PERIOD : period;
            ch_d         = mode ? first_ch : '0;
            cnt_d        = '0;
            stop_pend_d  = stop;
            start_d      = mode ? (NUM_CH'(1) << first_ch) : ch_mask;
            busy_d       = 1'b1;
            state_d      = S_FIRE;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_FIRE: begin
        stop_pend_d = 1'b0;
        if (stop_eff) begin
          start_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == FIRE_LAST) begin
          start_d = '0;
          cnt_d   = '0;
          state_d = S_WAIT;
          if (round_cmp && (rounds_done_q != '1)) begin
            rounds_done_d = rounds_done_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT: begin
        stop_pend_d = 1'b0;
        if (stop_eff) begin
          start_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == wait_last) begin
          cnt_d = '0;
          if ((rounds_q != '0) && (rounds_done_q == rounds_q)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            ch_d    = mode_q ? next_ch : '0;
            start_d = mode_q ? (NUM_CH'(1) << next_ch) : mask_q;
            state_d = S_FIRE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        stop_pend_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        start_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      mask_q        <= '0;
      rounds_q      <= '0;
      period_eff_q  <= '0;
      ch_q          <= '0;
      stop_pend_q   <= 1'b0;
      start_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rounds_done_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      mask_q        <= mask_d;
      rounds_q      <= rounds_d;
      period_eff_q  <= period_eff_d;
      ch_q          <= ch_d;
      stop_pend_q   <= stop_pend_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rounds_done_q <= rounds_done_d;
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cur_ch      = ch_q;
  assign rounds_done = rounds_done_q;

endmodule
